// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton conditioner: channel states, default
// 100 MHz timing and the game's button index names.
package button_pkg;

  typedef enum logic [2:0] {
    StArm,
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } btn_state_e;

  localparam int unsigned DefaultNumBtn         = 4;
  localparam int unsigned DefaultSyncStages     = 2;
  localparam int unsigned DefaultDebounceCycles = 1000000;   // 10 ms
  localparam int unsigned DefaultRepeatDelay    = 50000000;  // 500 ms
  localparam int unsigned DefaultRepeatPeriod   = 10000000;  // 100 ms

  // Bit positions in dpb/scen/mcen as used by the game logic.
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: input synchronizer, debounce FSM and auto-repeat counter.
// dpb, scen and mcen are all registered.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefaultSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic dpb,
  output logic scen,
  output logic mcen
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax);

  localparam logic [CntW-1:0] CntLast       = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [RptW-1:0]        rpt_q, rpt_d;
  logic [RptW-1:0]        rpt_limit;
  logic                   first_q, first_d;
  logic                   dpb_q, dpb_d;
  logic                   scen_q, scen_d;
  logic                   mcen_q, mcen_d;
  logic                   s;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], btn_raw};
  assign s         = sync_q[SYNC_STAGES-1];
  assign rpt_limit = first_q ? RptDelayLast : RptPeriodLast;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    first_d = first_q;
    scen_d  = 1'b0;
    mcen_d  = 1'b0;
    unique case (state_q)
      // A button held through reset must be seen released and stable first.
      StArm: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StHeld;
          rpt_d   = '0;
          first_d = 1'b1;
          scen_d  = 1'b1;
          mcen_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (rpt_q == rpt_limit) begin
          mcen_d  = 1'b1;
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
      // Repeat progress is frozen here so a short release glitch only delays it.
      StReleaseWait: begin
        if (s) begin
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StArm;
    endcase
    dpb_d = (state_d == StHeld) || (state_d == StReleaseWait);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= StArm;
      cnt_q   <= '0;
      rpt_q   <= '0;
      first_q <= 1'b0;
      dpb_q   <= 1'b0;
      scen_q  <= 1'b0;
      mcen_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
      dpb_q   <= dpb_d;
      scen_q  <= scen_d;
      mcen_q  <= mcen_d;
    end
  end

  assign dpb  = dpb_q;
  assign scen = scen_q;
  assign mcen = mcen_q;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent pushbutton channels producing debounced level, press strobe
// and auto-repeat strobe for the game logic.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = DefaultNumBtn,
  parameter int unsigned SYNC_STAGES     = DefaultSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] dpb,
  output logic [N_BTN-1:0] scen,
  output logic [N_BTN-1:0] mcen
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .dpb    (dpb[i]),
      .scen   (scen[i]),
      .mcen   (mcen[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: timing table, directed corner sequences and a
// randomized run against a run-length reference model.
module tb_button_conditioner;

  localparam int unsigned NB   = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned RD   = 10;
  localparam int unsigned RP   = 5;
  localparam int          LogLen = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] dpb, scen, mcen;

  button_conditioner #(
    .N_BTN          (NB),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .dpb    (dpb),
    .scen   (scen),
    .mcen   (mcen)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  logic [NB-1:0] dpb_log  [LogLen];
  logic [NB-1:0] scen_log [LogLen];
  logic [NB-1:0] mcen_log [LogLen];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < LogLen) begin
      dpb_log[cyc]  = dpb;
      scen_log[cyc] = scen;
      mcen_log[cyc] = mcen;
    end
  endtask

  task automatic hold(input logic [NB-1:0] b, input int n);
    btn_raw = b;
    repeat (n) tick();
  endtask

  // kind: 0 = dpb, 1 = scen, 2 = mcen; counts logged edges with any masked bit set.
  function automatic int count_hi(input int kind, input logic [NB-1:0] mask, input int lo,
                                  input int hi);
    int            n;
    logic [NB-1:0] v;
    n = 0;
    for (int k = lo; k <= hi; k++) begin
      v = (kind == 0) ? dpb_log[k] : (kind == 1) ? scen_log[k] : mcen_log[k];
      if ((v & mask) != '0) n++;
    end
    return n;
  endfunction

  // Reference model: the level flips once the synchronized input has disagreed with
  // it for DEB+1 consecutive samples; repeats count samples where the button was
  // already down on the previous and current sample.
  logic [NB-1:0] m_pipe [$];
  bit            m_armed [NB];
  bit            m_lvl   [NB];
  bit            m_runv  [NB];
  bit            m_prev  [NB];
  int            m_runl  [NB];
  int            m_hold  [NB];
  int            m_reps  [NB];
  logic [NB-1:0] m_dpb, m_scen, m_mcen;

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
    for (int c = 0; c < NB; c++) begin
      m_armed[c] = 0; m_lvl[c] = 0; m_runv[c] = 0; m_prev[c] = 0;
      m_runl[c]  = 0; m_hold[c] = 0; m_reps[c] = 0;
    end
    m_dpb = '0; m_scen = '0; m_mcen = '0;
  endtask

  task automatic model_step(input logic [NB-1:0] b);
    logic [NB-1:0] sv;
    bit            s;
    sv = m_pipe.pop_front();
    m_pipe.push_back(b);
    m_scen = '0;
    m_mcen = '0;
    for (int c = 0; c < NB; c++) begin
      s = sv[c];
      if (s == m_runv[c]) m_runl[c]++;
      else begin
        m_runv[c] = s;
        m_runl[c] = 1;
      end
      if (!m_armed[c]) begin
        if (!s && m_runl[c] == DEB) m_armed[c] = 1;
      end else if (s != m_lvl[c] && m_runl[c] == DEB + 1) begin
        m_lvl[c] = s;
        if (s) begin
          m_scen[c] = 1'b1;
          m_mcen[c] = 1'b1;
          m_hold[c] = 0;
          m_reps[c] = 0;
        end
      end else if (m_lvl[c] && s && m_prev[c]) begin
        m_hold[c]++;
        if (m_hold[c] == ((m_reps[c] == 0) ? RD : RP)) begin
          m_mcen[c] = 1'b1;
          m_hold[c] = 0;
          m_reps[c]++;
        end
      end
      m_prev[c] = s;
      m_dpb[c]  = m_lvl[c];
    end
  endtask

  typedef struct {
    int            at;
    logic [NB-1:0] dpb;
    logic [NB-1:0] scen;
    logic [NB-1:0] mcen;
  } vec_t;

  vec_t tv [14];

  initial begin
    int            t0, t1, t2, ti;
    int unsigned   rate;
    logic [NB-1:0] lvl;
    bit            r;

    // Test 1 expectations, edge 0 = first edge sampling btn_raw[0]=1 (held 40 edges).
    tv[0]  = '{5,  4'h0, 4'h0, 4'h0};
    tv[1]  = '{6,  4'h1, 4'h1, 4'h1};
    tv[2]  = '{7,  4'h1, 4'h0, 4'h0};
    tv[3]  = '{15, 4'h1, 4'h0, 4'h0};
    tv[4]  = '{16, 4'h1, 4'h0, 4'h1};
    tv[5]  = '{17, 4'h1, 4'h0, 4'h0};
    tv[6]  = '{20, 4'h1, 4'h0, 4'h0};
    tv[7]  = '{21, 4'h1, 4'h0, 4'h1};
    tv[8]  = '{26, 4'h1, 4'h0, 4'h1};
    tv[9]  = '{31, 4'h1, 4'h0, 4'h1};
    tv[10] = '{36, 4'h1, 4'h0, 4'h1};
    tv[11] = '{41, 4'h1, 4'h0, 4'h1};
    tv[12] = '{45, 4'h1, 4'h0, 4'h0};
    tv[13] = '{46, 4'h0, 4'h0, 4'h0};

    reset   = 1'b1;
    btn_raw = '0;
    tick();
    tick();
    check("reset_dpb", dpb, 0);
    check("reset_scen", scen, 0);
    check("reset_mcen", mcen, 0);
    reset = 1'b0;
    hold('0, 10);

    // Test 1: clean press and release on channel 0.
    ti = 0;
    for (int k = 0; k <= 50; k++) begin
      btn_raw = (k < 40) ? 4'b0001 : 4'b0000;
      tick();
      if (ti < 14 && tv[ti].at == k) begin
        check($sformatf("t1_dpb_e%0d", k), dpb, tv[ti].dpb);
        check($sformatf("t1_scen_e%0d", k), scen, tv[ti].scen);
        check($sformatf("t1_mcen_e%0d", k), mcen, tv[ti].mcen);
        ti++;
      end
    end
    hold('0, 5);

    // Test 2: bouncy press on channel 1.
    t0 = cyc + 1;
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 4'b0010 : 4'b0000, 2);
    check("t2_quiet_bounce", count_hi(0, 4'hF, t0, t0 + 11) + count_hi(1, 4'hF, t0, t0 + 11)
          + count_hi(2, 4'hF, t0, t0 + 11), 0);
    hold(4'b0010, 20);
    check("t2_scen_count", count_hi(1, 4'hF, t0, t0 + 31), 1);
    check("t2_scen_edge", scen_log[t0 + 18], 4'b0010);
    check("t2_mcen_count", count_hi(2, 4'b0010, t0, t0 + 31), 2);
    hold('0, 10);
    check("t2_released", dpb, 0);

    // Test 3: 2-cycle release glitch while held on channel 2.
    t0 = cyc + 1;
    hold(4'b0100, 12);
    hold(4'b0000, 2);
    hold(4'b0100, 20);
    check("t3_scen_count", count_hi(1, 4'b0100, t0, t0 + 33), 1);
    check("t3_dpb_steady", count_hi(0, 4'b0100, t0 + 6, t0 + 33), 28);
    check("t3_mcen_count", count_hi(2, 4'b0100, t0, t0 + 33), 4);
    // Glitch costs the two RELEASE_WAIT samples plus the low sample that entered it.
    check("t3_mcen_not16", mcen_log[t0 + 16], 0);
    check("t3_mcen_at19", mcen_log[t0 + 19], 4'b0100);
    check("t3_mcen_at24", mcen_log[t0 + 24], 4'b0100);
    hold('0, 10);

    // Test 4: simultaneous presses on channels 1 and 3.
    t0 = cyc + 1;
    hold(4'b1010, 10);
    check("t4_scen_before", scen_log[t0 + 5], 0);
    check("t4_scen_same", scen_log[t0 + 6], 4'b1010);
    check("t4_mcen_same", mcen_log[t0 + 6], 4'b1010);
    check("t4_scen_after", scen_log[t0 + 7], 0);
    hold('0, 10);

    // Test 5: reset while channel 2 is held.
    hold(4'b0100, 12);
    check("t5_held", dpb, 4'b0100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_dpb", dpb, 0);
    check("t5_rst_scen", scen, 0);
    check("t5_rst_mcen", mcen, 0);
    t1 = cyc + 1;
    hold(4'b0100, 20);
    check("t5_ignored_held", count_hi(0, 4'hF, t1, t1 + 19) + count_hi(1, 4'hF, t1, t1 + 19)
          + count_hi(2, 4'hF, t1, t1 + 19), 0);
    hold('0, 8);
    t2 = cyc + 1;
    hold(4'b0100, 12);
    check("t5_repress_count", count_hi(1, 4'hF, t2, t2 + 11), 1);
    check("t5_repress_edge", scen_log[t2 + 6], 4'b0100);
    hold('0, 10);

    // Test 6: 3-cycle pulse is rejected.
    t0 = cyc + 1;
    hold(4'b0001, 3);
    hold(4'b0000, 20);
    check("t6_pulse_rejected", count_hi(0, 4'hF, t0, t0 + 22) + count_hi(1, 4'hF, t0, t0 + 22)
          + count_hi(2, 4'hF, t0, t0 + 22), 0);

    // Randomized run against the model, with occasional resets.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    lvl  = '0;
    rate = 4;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) rate = ($urandom_range(0, 1) == 1) ? 4 : 40;
      for (int c = 0; c < NB; c++) if ($urandom_range(0, rate - 1) == 0) lvl[c] = ~lvl[c];
      r       = ($urandom_range(0, 999) == 0);
      btn_raw = lvl;
      reset   = r;
      tick();
      reset = 1'b0;
      if (r) model_reset();
      else model_step(lvl);
      check($sformatf("rand_dpb_c%0d", n), dpb, m_dpb);
      check($sformatf("rand_scen_c%0d", n), scen, m_scen);
      check($sformatf("rand_mcen_c%0d", n), mcen, m_mcen);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
